// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel enable-qualified CDC capture with round-robin merge into one valid/ready stream
//
// Ports:
//   CLK          destination clock
//   RST          asynchronous active-low reset
//   bus_enable   per-channel unsynchronized enable (level) or toggle
//   unsync_bus   per-channel data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   sync_bus     per-channel captured data, same packing
//   enable_pulse one-cycle capture strobe per channel
//   out_valid    merged stream word valid
//   out_ch       channel of out_data
//   out_data     merged stream data
//   out_ready    merged stream consumer ready
//   overrun      sticky per-channel overrun flags
//   overrun_clr  clears all overrun flags
//
// Optional feature: define DATA_SYNC_OVERRUN_EN to store overrun flags;
// without it overrun is tied low and overrun_clr is ignored.
module data_sync_mc #(
  parameter int NUM_CH      = 2,
  parameter int NUM_STAGES  = 2,
  parameter int BUS_WIDTH   = 8,
  parameter int TOGGLE_MODE = 0,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_CH-1:0]             bus_enable,
  input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
  output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
  output logic [NUM_CH-1:0]             enable_pulse,
  output logic                          out_valid,
  output logic [CH_W-1:0]               out_ch,
  output logic [BUS_WIDTH-1:0]          out_data,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0]             overrun,
  input  logic                          overrun_clr
);
  logic [NUM_STAGES-1:0] r_sync [NUM_CH];
  logic [BUS_WIDTH-1:0]  r_pend_data [NUM_CH];
  logic [NUM_CH-1:0]     r_prev, r_pend;
  logic [CH_W-1:0]       r_ptr, w_grant;
  logic [NUM_CH-1:0]     w_en_s, w_edge, w_take, w_ovr_ev;
  logic                  w_found, w_load;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_en_s[c] = r_sync[c][NUM_STAGES-1];
  end

  assign w_edge = (TOGGLE_MODE != 0) ? (w_en_s ^ r_prev) : (w_en_s & ~r_prev);
  assign w_load = !out_valid || out_ready;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!w_found && r_pend[(int'(r_ptr) + k) % NUM_CH]) begin
        w_found = 1'b1;
        w_grant = CH_W'((int'(r_ptr) + k) % NUM_CH);
      end
    end
  end

  assign w_take   = (w_load && w_found) ? (NUM_CH'(1) << w_grant) : '0;
  // A fresh edge on a channel still holding an ungranted word drops the old word.
  assign w_ovr_ev = w_edge & r_pend & ~w_take;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_sync[c]      <= '0;
        r_pend_data[c] <= '0;
      end
      r_prev       <= '0;
      r_pend       <= '0;
      r_ptr        <= CH_W'(NUM_CH - 1);
      sync_bus     <= '0;
      enable_pulse <= '0;
      out_valid    <= 1'b0;
      out_ch       <= '0;
      out_data     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_sync[c] <= {r_sync[c][NUM_STAGES-2:0], bus_enable[c]};
        if (w_edge[c]) begin
          sync_bus[c*BUS_WIDTH +: BUS_WIDTH] <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
          r_pend_data[c]                     <= unsync_bus[c*BUS_WIDTH +: BUS_WIDTH];
        end
      end
      r_prev       <= w_en_s;
      enable_pulse <= w_edge;
      // A new edge wins over a same-cycle grant clear, so the new word stays pending.
      r_pend       <= (r_pend & ~w_take) | w_edge;
      if (w_load) begin
        out_valid <= w_found;
        if (w_found) begin
          out_ch   <= w_grant;
          out_data <= r_pend_data[w_grant];
          r_ptr    <= w_grant;
        end
      end
    end
  end

`ifdef DATA_SYNC_OVERRUN_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) overrun <= '0;
    else overrun <= overrun_clr ? '0 : (overrun | w_ovr_ev);
  end
`else
  logic w_unused;
  assign w_unused = overrun_clr | (|w_ovr_ev);
  assign overrun  = '0;
`endif
endmodule

// File: tb/tb_data_sync_mc.sv
// tb_data_sync_mc: directed self-checking bench for data_sync_mc (level and toggle instances)
module tb_data_sync_mc;
  logic        CLK, RST;
  logic [1:0]  be, ep, ovr, b_be, b_ep, b_ovr;
  logic [15:0] ub, sb, b_ub, b_sb;
  logic        rdy, clr, ov, och, b_rdy, b_clr, b_ov, b_och;
  logic [7:0]  od, b_od;
  int          checks = 0, failures = 0;
`ifdef DATA_SYNC_OVERRUN_EN
  localparam logic [1:0] OVR_EXP = 2'b01;
`else
  localparam logic [1:0] OVR_EXP = 2'b00;
`endif

  data_sync_mc #(.TOGGLE_MODE(0)) dut_a (
    .CLK(CLK), .RST(RST), .bus_enable(be), .unsync_bus(ub), .sync_bus(sb),
    .enable_pulse(ep), .out_valid(ov), .out_ch(och), .out_data(od),
    .out_ready(rdy), .overrun(ovr), .overrun_clr(clr)
  );

  data_sync_mc #(.TOGGLE_MODE(1)) dut_b (
    .CLK(CLK), .RST(RST), .bus_enable(b_be), .unsync_bus(b_ub), .sync_bus(b_sb),
    .enable_pulse(b_ep), .out_valid(b_ov), .out_ch(b_och), .out_data(b_od),
    .out_ready(b_rdy), .overrun(b_ovr), .overrun_clr(b_clr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] en, input logic [15:0] d);
    be = en;
    ub = d;
    tick();
    be = 2'b00;
    tick();
    tick();
  endtask

  task automatic rst_pulse();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    tick();
  endtask

  initial begin
    // reset with random inputs
    RST = 1'b0;
    be = 2'($urandom); ub = 16'($urandom); rdy = 1'($urandom); clr = 1'($urandom);
    b_be = 2'($urandom); b_ub = 16'($urandom); b_rdy = 1'($urandom); b_clr = 1'($urandom);
    tick(); tick();
    chk("rst_sb", 32'(sb), 0);
    chk("rst_ep", 32'(ep), 0);
    chk("rst_ov", 32'(ov), 0);
    chk("rst_och", 32'(och), 0);
    chk("rst_od", 32'(od), 0);
    chk("rst_ovr", 32'(ovr), 0);
    chk("rst_b_sb", 32'(b_sb), 0);
    chk("rst_b_ov", 32'(b_ov), 0);
    be = 0; ub = 0; rdy = 0; clr = 0;
    b_be = 0; b_ub = 0; b_rdy = 0; b_clr = 0;
    RST = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_ep", 32'(ep), 0);
    chk("post_rst_ov", 32'(ov), 0);
    chk("post_rst_sb", 32'(sb), 0);
    // single capture on ch0
    be = 2'b01; ub = 16'h0055;
    tick();
    be = 2'b00;
    tick();
    chk("t2_ep_early", 32'(ep), 0);
    tick();
    chk("t2_ep", 32'(ep), 32'h1);
    chk("t2_sb", 32'(sb), 32'h0055);
    chk("t2_ov_pre", 32'(ov), 0);
    rdy = 1'b1;
    tick();
    chk("t2_ep_off", 32'(ep), 0);
    chk("t2_ov", 32'(ov), 1);
    chk("t2_och", 32'(och), 0);
    chk("t2_od", 32'(od), 32'h55);
    tick();
    chk("t2_ov_drain", 32'(ov), 0);
    // simultaneous ch0/ch1, twice, from a fresh pointer
    rst_pulse();
    for (int r = 0; r < 2; r++) begin
      send(2'b11, 16'h33AA);
      chk("t3_ep", 32'(ep), 32'h3);
      chk("t3_sb", 32'(sb), 32'h33AA);
      tick();
      chk("t3_first_ch", 32'(och), 0);
      chk("t3_first_od", 32'(od), 32'hAA);
      chk("t3_first_ov", 32'(ov), 1);
      tick();
      chk("t3_second_ch", 32'(och), 1);
      chk("t3_second_od", 32'(od), 32'h33);
      chk("t3_second_ov", 32'(ov), 1);
      tick();
      chk("t3_drain_ov", 32'(ov), 0);
    end
    // backpressure and overrun on ch0
    rdy = 1'b0;
    send(2'b01, 16'h0011);
    send(2'b01, 16'h0022);
    chk("t4_hold_od", 32'(od), 32'h11);
    chk("t4_ovr_none", 32'(ovr), 0);
    send(2'b01, 16'h0044);
    chk("t4_ep", 32'(ep), 32'h1);
    chk("t4_sb", 32'(sb[7:0]), 32'h44);
    chk("t4_ov", 32'(ov), 1);
    chk("t4_od_held", 32'(od), 32'h11);
    tick();
    chk("t4_ovr", 32'(ovr), 32'(OVR_EXP));
    rdy = 1'b1;
    tick();
    chk("t4_next_od", 32'(od), 32'h44);
    chk("t4_next_ov", 32'(ov), 1);
    tick();
    chk("t4_drain_ov", 32'(ov), 0);
    chk("t4_ovr_sticky", 32'(ovr), 32'(OVR_EXP));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t4_ovr_clr", 32'(ovr), 0);
    // toggle mode instance
    b_rdy = 1'b1;
    b_be = 2'b01; b_ub = 16'h005A;
    tick(); tick(); tick();
    chk("t5_ep_rise", 32'(b_ep), 32'h1);
    chk("t5_sb_rise", 32'(b_sb), 32'h005A);
    tick();
    chk("t5_ep_once", 32'(b_ep), 0);
    chk("t5_od_rise", 32'(b_od), 32'h5A);
    chk("t5_ov_rise", 32'(b_ov), 1);
    b_be = 2'b00; b_ub = 16'h00A5;
    tick(); tick(); tick();
    chk("t5_ep_fall", 32'(b_ep), 32'h1);
    chk("t5_sb_fall", 32'(b_sb), 32'h00A5);
    tick();
    chk("t5_ep_fall_once", 32'(b_ep), 0);
    chk("t5_od_fall", 32'(b_od), 32'hA5);
    chk("t5_ov_fall", 32'(b_ov), 1);
    // reset while an enable is in flight
    rst_pulse();
    be = 2'b01; ub = 16'h0077;
    tick();
    RST = 1'b0;
    be = 2'b00;
    tick();
    RST = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_ep", 32'(ep), 0);
      chk("t6_ov", 32'(ov), 0);
    end
    chk("t6_sb", 32'(sb), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
